// File: rtl/inverse_seq.sv
// -----------------------------------------------------------------------------
// inverse_seq
//
// Run-phase sequencer for the matrix-inverse datapath. It owns the whole
// inversion schedule, so no free-running counter is needed elsewhere:
//   1. A start pulse in IDLE moves to CLEAR.
//   2. CLEAR holds the datapath in reset for exactly one cycle.
//   3. RUN steps count 0..MAX-1, one step per enabled cycle. A stall holds
//      count, mm_rst and the state for that cycle.
//   4. DONE pulses done for one cycle, then the sequencer returns to IDLE.
//
// The mat_mult and array_mult control lines are derived from count:
//   - mm_rst rises one enabled cycle after count hits MMR0, MMR1 or MMR2.
//   - mm_mode is 0 (element-wise) for MODE_LO <= count < MODE_HI, else 1.
//
// Optional build feature, enabled by defining the macro
// INVERSE_SEQ_STALL_CNT_EN:
//   Adds stall_cycles[15:0], a saturating count of RUN cycles with stall=1.
//   It is cleared by rst and in CLEAR, and holds after DONE.
//
// Ports
//   clk           in   1      clock
//   rst           in   1      synchronous active-high reset
//   start         in   1      request one pass; sampled only in IDLE
//   stall         in   1      hold the datapath this cycle (RUN only)
//   busy          out  1      high in CLEAR, RUN and DONE
//   done          out  1      one-cycle pulse at pass completion
//   inv_rst       out  1      datapath reset
//   inv_en        out  1      datapath enable (combinational)
//   count         out  CNT_W  schedule position
//   mm_rst        out  1      mat_mult accumulator reset, registered
//   mm_mode       out  1      mat_mult mode (combinational from count)
//   stall_cycles  out  16     stall counter (only with the macro defined)
//   am_rst        out  1      array_mult reset, equal to inv_rst
// -----------------------------------------------------------------------------
module inverse_seq #(
    parameter int CNT_W   = 8,
    parameter int MAX     = 229,
    parameter int MMR0    = 28,
    parameter int MMR1    = 98,
    parameter int MMR2    = 214,
    parameter int MODE_LO = 89,
    parameter int MODE_HI = 98
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             inv_rst,
    output logic             inv_en,
    output logic [CNT_W-1:0] count,
    output logic             mm_rst,
    output logic             mm_mode,
`ifdef INVERSE_SEQ_STALL_CNT_EN
    output logic [15:0]      stall_cycles,
`endif
    output logic             am_rst
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_LAST    = CNT_W'(MAX - 1);
    localparam logic [CNT_W-1:0] L_MMR0    = CNT_W'(MMR0);
    localparam logic [CNT_W-1:0] L_MMR1    = CNT_W'(MMR1);
    localparam logic [CNT_W-1:0] L_MMR2    = CNT_W'(MMR2);
    localparam logic [CNT_W-1:0] L_MODE_LO = CNT_W'(MODE_LO);
    localparam logic [CNT_W-1:0] L_MODE_HI = CNT_W'(MODE_HI);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic             r_mm_rst;
    logic             r_done;
    logic             r_busy;
    logic             r_inv_rst;
    logic             w_inv_en;
    logic             w_mm_hit;
    logic             w_last;

    assign w_mm_hit = (r_count == L_MMR0) | (r_count == L_MMR1) | (r_count == L_MMR2);
    assign w_last   = (r_count == L_LAST);

    // -------------------------------------------------------------------------
    // State register, plus the registered outputs. done, busy and inv_rst are
    // decoded from the next state so they line up with the state they describe.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_mm_rst  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_inv_rst <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_done    <= (w_next_state == S_DONE);
            r_busy    <= (w_next_state != S_IDLE);
            r_inv_rst <= (w_next_state == S_CLEAR);

            case (r_state)
                S_IDLE: begin
                    // Entering CLEAR: present count=0 and mm_rst=0 during it.
                    if (start) begin
                        r_count  <= '0;
                        r_mm_rst <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_count  <= '0;
                    r_mm_rst <= 1'b0;
                end
                S_RUN: begin
                    // A stalled cycle leaves count and mm_rst untouched.
                    if (w_inv_en) begin
                        r_mm_rst <= w_mm_hit;
                        r_count  <= w_last ? '0 : r_count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_mm_rst <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment first means every path drives
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CLEAR;
            S_CLEAR: w_next_state = S_RUN;
            S_RUN:   if (w_inv_en && w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_inv_en = (r_state == S_RUN) && !stall;
        mm_mode  = !((r_count >= L_MODE_LO) && (r_count < L_MODE_HI));
    end

`ifdef INVERSE_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating counter: it stays at 16'hFFFF instead of wrapping to zero.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_CLEAR)) begin
            r_stall_cycles <= '0;
        end else if ((r_state == S_RUN) && stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign inv_rst = r_inv_rst;
    assign am_rst  = r_inv_rst;
    assign inv_en  = w_inv_en;
    assign count   = r_count;
    assign mm_rst  = r_mm_rst;

endmodule

// File: tb/tb_inverse_seq.sv
// -----------------------------------------------------------------------------
// tb_inverse_seq
//
// Directed bench for inverse_seq. Inputs change 1 time unit after the rising
// edge, and outputs are sampled just after that. The schedule's expected
// values come from a small cycle model that tracks count, mm_rst and the
// stall plan.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inverse_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic       inv_rst;
    logic       inv_en;
    logic [7:0] count;
    logic       mm_rst;
    logic       mm_mode;
    logic       am_rst;
`ifdef INVERSE_SEQ_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int stall_map [0:255];

    inverse_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .inv_rst (inv_rst),
        .inv_en  (inv_en),
        .count   (count),
        .mm_rst  (mm_rst),
        .mm_mode (mm_mode),
`ifdef INVERSE_SEQ_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .am_rst  (am_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 256; i++) stall_map[i] = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   busy,    1'b0);
        check({tag, "_done"},   done,    1'b0);
        check({tag, "_inv_en"}, inv_en,  1'b0);
        check({tag, "_count"},  count,   0);
        check({tag, "_mode"},   mm_mode, 1'b1);
    endtask

    // One pass from a start pulse (cycle 0) to IDLE. Stalls follow stall_map:
    // stall_map[c] stall cycles are inserted the first time count shows c.
    //   start_at      pulse start while count == start_at (-1: never)
    //   start_in_done raise start in the DONE cycle
    //   abort_at      assert rst while count == abort_at (-1: never)
    //   stall_out     hold stall high in CLEAR and DONE
    //   exp_stalls    total stall cycles expected in RUN
    task automatic run_pass(input int start_at, input bit start_in_done, input int abort_at,
                            input bit stall_out, input int exp_stalls);
        int  cyc;
        int  exp_cnt;
        bit  exp_mm;
        int  pend;
        int  prev;
        bit  finished;

        // Cycle 0: start pulse from IDLE.
        start = 1'b1;
        stall = 1'b0;
        #1;
        check("pre_busy", busy, 1'b0);
        step();
        start = 1'b0;
        stall = stall_out;
        #1;
        // Cycle 1: CLEAR.
        check("clr_inv_rst", inv_rst, 1'b1);
        check("clr_am_rst",  am_rst,  1'b1);
        check("clr_busy",    busy,    1'b1);
        check("clr_inv_en",  inv_en,  1'b0);
        check("clr_count",   count,   0);
        check("clr_mm_rst",  mm_rst,  1'b0);
        step();
        cyc = 2;
        stall = 1'b0;
`ifdef INVERSE_SEQ_STALL_CNT_EN
        check("sc_cleared", stall_cycles, 0);
`endif
        check("run_inv_rst", inv_rst, 1'b0);

        exp_cnt  = 0;
        exp_mm   = 1'b0;
        prev     = -1;
        pend     = 0;
        finished = 1'b0;
        for (int guard = 0; guard < 400 && !finished; guard++) begin
            if (exp_cnt != prev) begin
                pend = stall_map[exp_cnt];
                prev = exp_cnt;
            end
            stall = (pend > 0);
            start = (exp_cnt == start_at);
            if (exp_cnt == abort_at) begin
                stall = 1'b0;
                start = 1'b0;
                rst   = 1'b1;
                step();
                check("abort_count",   count,   0);
                check("abort_mm_rst",  mm_rst,  1'b0);
                check("abort_busy",    busy,    1'b0);
                check("abort_done",    done,    1'b0);
                check("abort_inv_rst", inv_rst, 1'b1);
                check("abort_inv_en",  inv_en,  1'b0);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check("abort_idle_inv_rst", inv_rst, 1'b0);
                    check_idle("abort_idle");
                end
                return;
            end
            #1;
            check("run_count",  count,   exp_cnt);
            check("run_mm_rst", mm_rst,  exp_mm);
            check("run_mode",   mm_mode, !(exp_cnt >= 89 && exp_cnt < 98));
            check("run_inv_en", inv_en,  !stall);
            check("run_done",   done,    1'b0);
            step();
            cyc++;
            if (!stall) begin
                exp_mm = (exp_cnt == 28) || (exp_cnt == 98) || (exp_cnt == 214);
                if (exp_cnt == 228) finished = 1'b1;
                else exp_cnt++;
            end else begin
                pend--;
            end
        end
        check("pass_finished", finished, 1'b1);

        // DONE cycle.
        start = start_in_done;
        stall = stall_out;
        start = start_in_done;
        #1;
        check("done_pulse",  done,   1'b1);
        check("done_cycle",  cyc,    231 + exp_stalls);
        check("done_busy",   busy,   1'b1);
        check("done_inv_en", inv_en, 1'b0);
        check("done_count",  count,  0);
        check("done_mm_rst", mm_rst, 1'b0);
`ifdef INVERSE_SEQ_STALL_CNT_EN
        check("sc_at_done", stall_cycles, exp_stalls);
`endif
        step();
        start = 1'b0;
        stall = 1'b0;
        // Back in IDLE; a start raised in DONE must not have opened a new pass.
        for (int k = 0; k < 4; k++) begin
            check_idle("post");
            check("post_inv_rst", inv_rst, 1'b0);
`ifdef INVERSE_SEQ_STALL_CNT_EN
            check("sc_hold", stall_cycles, exp_stalls);
`endif
            step();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        clear_map();

        // Reset for 3 cycles, then idle for 10 with start low.
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle("rst");
            check("rst_inv_rst", inv_rst, 1'b1);
            check("rst_mm_rst",  mm_rst,  1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            // Stall in IDLE must not enable the datapath.
            stall = (k >= 5);
            step();
            check_idle("idle");
            check("idle_inv_rst", inv_rst, 1'b0);
        end
        stall = 1'b0;

        // Clean pass.
        run_pass(-1, 1'b0, -1, 1'b0, 0);

        // 5-cycle stall at count 28: done moves to cycle 236.
        clear_map();
        stall_map[28] = 5;
        run_pass(-1, 1'b0, -1, 1'b0, 5);

        // Start while busy: at count 50 and in the DONE cycle.
        clear_map();
        run_pass(50, 1'b1, -1, 1'b0, 0);

        // Reset mid-pass at count 120, then a full pass.
        run_pass(-1, 1'b0, 120, 1'b0, 0);
        run_pass(-1, 1'b0, -1, 1'b0, 0);

        // Scattered stalls (7 in RUN), including one where mm_rst is high at
        // count 99, plus stall held in CLEAR and DONE, which must not count.
        stall_map[10]  = 2;
        stall_map[99]  = 1;
        stall_map[200] = 4;
        run_pass(-1, 1'b0, -1, 1'b1, 7);

        // The next CLEAR clears the stall counter.
        clear_map();
        run_pass(-1, 1'b0, -1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
